// File: rtl/seg_bcd_scan.sv
// Free-running binary-to-BCD converter (sequential double-dabble) feeding a
// 6-digit multiplexed common-anode display. Optional: SEG_LEADING_ZERO_BLANK_EN.
module seg_bcd_scan #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SCAN_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [19:0] num,
  output logic [23:0] bcd_out,
  output logic        bcd_valid,
  output logic [5:0]  seg_sel_n,
  output logic [7:0]  seg_data
);

  localparam int unsigned DIV = CLK_FREQ / SCAN_HZ;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [19:0]   bin_q, bin_d;
  logic [23:0]   bcd_q, bcd_d;
  logic [23:0]   bcd_out_q, bcd_out_d;
  logic [23:0]   adj;
  logic [19:0]   num_clamped;
  logic          load_en, shift_en;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    dat_q, dat_d;
  logic [3:0]    nib;
  logic [5:0]    blank;

  function automatic logic [7:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 8'hC0;
      4'd1:    encode = 8'hF9;
      4'd2:    encode = 8'hA4;
      4'd3:    encode = 8'hB0;
      4'd4:    encode = 8'h99;
      4'd5:    encode = 8'h92;
      4'd6:    encode = 8'h82;
      4'd7:    encode = 8'hF8;
      4'd8:    encode = 8'h80;
      4'd9:    encode = 8'h90;
      default: encode = 8'hFF;
    endcase
  endfunction

  assign num_clamped = (num > 20'd999999) ? 20'd999999 : num;

  // Converter FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == 5'd19) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_en   = (state_q == LOAD);
    shift_en  = (state_q == SHIFT);
    bcd_valid = (state_q == DONE);
  end

  // The final shift is written straight to bcd_out so it changes in the DONE cycle.
  always_comb begin
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bcd_out_d = bcd_out_q;
    adj       = bcd_q;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (load_en) begin
      bin_d = num_clamped;
      bcd_d = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      bin_d = {bin_q[18:0], 1'b0};
      bcd_d = {adj[22:0], bin_q[19]};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd19) bcd_out_d = {adj[22:0], bin_q[19]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      bcd_out_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bcd_out_q <= bcd_out_d;
    end
  end

  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // A digit is blanked when it and every digit above it are zero; ones always shown.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int unsigned i = 5; i >= 1; i--) begin
      seen = seen | (bcd_out_q[4*i +: 4] != 4'd0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      blank[i] = ~seen;
`else
      blank[i] = 1'b0;
`endif
    end
  end

  always_comb begin
    nib = 4'd0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (idx_q == 3'(i)) nib = bcd_out_q[4*i +: 4];
    end
    sel_d = '1;
    dat_d = '1;
    if (en) begin
      sel_d = ~(6'd1 << idx_q);
      dat_d = blank[idx_q] ? 8'hFF : encode(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      sel_q <= '1;
      dat_q <= '1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      dat_q <= dat_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign seg_sel_n = sel_q;
  assign seg_data  = dat_q;

endmodule

// File: tb/tb_seg_bcd_scan.sv
// Directed bench for seg_bcd_scan with a 10-cycle digit slot; expected digit
// patterns follow SEG_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg_bcd_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [19:0] num;
  logic [23:0] bcd_out;
  logic        bcd_valid;
  logic [5:0]  seg_sel_n;
  logic [7:0]  seg_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_d [6];
  logic [5:0]  exp_sel [6];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  seg_bcd_scan #(.CLK_FREQ(1000), .SCAN_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .num(num),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid),
    .seg_sel_n(seg_sel_n), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv_check(input string tag, input logic [19:0] n, input logic [23:0] exp);
    int cyc;
    num = n;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(bcd_valid && bcd_out == exp) && cyc < 46);
    chk({tag, "_val"}, bcd_out, exp);
    chk({tag, "_vld"}, bcd_valid, 1);
    tick();
    chk({tag, "_pulse"}, bcd_valid, 0);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bcd_valid && cyc < 60);
  endtask

  task automatic scan_check(input string tag);
    logic [5:0] prev;
    int cyc;
    cyc  = 0;
    prev = seg_sel_n;
    tick();
    while (!(seg_sel_n == 6'h3E && prev != 6'h3E) && cyc < 80) begin
      prev = seg_sel_n;
      tick();
      cyc++;
    end
    chk({tag, "_sync"}, seg_sel_n, 6'h3E);
    for (int k = 0; k < 7; k++) begin
      chk({tag, "_sel"}, seg_sel_n, exp_sel[k % 6]);
      if (k < 6) chk({tag, "_dig"}, seg_data, exp_d[k]);
      repeat (9) tick();
      chk({tag, "_hold"}, seg_sel_n, exp_sel[k % 6]);
      tick();
    end
  endtask

  task automatic set_digits(input logic [7:0] d5, d4, d3, d2, d1, d0);
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
    exp_d[3] = d3; exp_d[4] = d4; exp_d[5] = d5;
  endtask

  initial begin
    int cyc;
    int bad;
    exp_sel[0] = 6'h3E; exp_sel[1] = 6'h3D; exp_sel[2] = 6'h3B;
    exp_sel[3] = 6'h37; exp_sel[4] = 6'h2F; exp_sel[5] = 6'h1F;
    rst_n = 1'b0;
    en    = 1'b1;
    num   = 20'd0;
    repeat (3) tick();
    chk("rst_bcd", bcd_out, 24'h000000);
    chk("rst_vld", bcd_valid, 0);
    chk("rst_sel", seg_sel_n, 6'h3F);
    chk("rst_dat", seg_data, 8'hFF);

    rst_n = 1'b1;
    num   = 20'd127;
    wait_valid(cyc);
    chk("first_conv_lat", cyc, 22);
    chk("first_conv_val", bcd_out, 24'h000127);

    conv_check("n127", 20'd127, 24'h000127);
    set_digits(LZ, LZ, LZ, 8'hF9, 8'hA4, 8'hF8);
    scan_check("s127");

    conv_check("clamp_max", 20'd1048575, 24'h999999);
    conv_check("zero", 20'd0, 24'h000000);
    set_digits(LZ, LZ, LZ, LZ, LZ, 8'hC0);
    scan_check("s0");
    conv_check("clamp_1e6", 20'd1000000, 24'h999999);
    conv_check("n255", 20'd255, 24'h000255);
    set_digits(LZ, LZ, LZ, 8'hA4, 8'h92, 8'h92);
    scan_check("s255");
    conv_check("n999999", 20'd999999, 24'h999999);
    set_digits(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90);
    scan_check("s999999");

    conv_check("n255b", 20'd255, 24'h000255);
    wait_valid(cyc);
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", bcd_out, 24'h000000);
    chk("mid_rst_vld", bcd_valid, 0);
    chk("mid_rst_sel", seg_sel_n, 6'h3F);
    chk("mid_rst_dat", seg_data, 8'hFF);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_valid(cyc);
    chk("rel_lat", cyc, 22);
    chk("rel_val", bcd_out, 24'h000255);

    conv_check("n127b", 20'd127, 24'h000127);
    en  = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (seg_sel_n != 6'h3F || seg_data != 8'hFF) bad++;
      tick();
    end
    chk("en0_blank", bad, 0);
    wait_valid(cyc);
    wait_valid(cyc);
    chk("en0_period", cyc, 23);
    chk("en0_val", bcd_out, 24'h000127);
    en = 1'b1;
    set_digits(LZ, LZ, LZ, 8'hF9, 8'hA4, 8'hF8);
    scan_check("s127b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_bcd_scan.md
SEG_BCD_SCAN -- requirements
Module: seg_bcd_scan

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter SCAN_HZ, default 1000, meaning the digit-advance rate in Hz (one digit slot = CLK_FREQ/SCAN_HZ cycles).
REQ-003 The module SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port en, input, 1 bit: display enable; low blanks all digits.
REQ-006 The module SHALL have port num, input, 20 bits: unsigned binary value to display, taken from the threshold/setting register.
REQ-007 The module SHALL have port bcd_out, output, 24 bits: six packed BCD digits of the last completed conversion, with the ones digit in [3:0].
REQ-008 The module SHALL have port bcd_valid, output, 1 bit: one-cycle pulse when bcd_out updates.
REQ-009 The module SHALL have port seg_sel_n, output, 6 bits: digit select, active low, one-hot; bit0 = ones digit.
REQ-010 The module SHALL have port seg_data, output, 8 bits: segment pattern for a common-anode display, active low; bit7 = dp, bits6..0 = g..a.

Function
REQ-011 Before conversion, the module SHALL clamp num: values above 999999 become 999999.
REQ-012 The converter FSM SHALL have states IDLE, LOAD, SHIFT, DONE, with transitions IDLE->LOAD (1 cycle), LOAD->SHIFT, SHIFT 20 cycles, DONE->IDLE; this is free-running, 23 cycles per conversion.
REQ-013 In LOAD, the FSM SHALL capture the clamped num; changes to num during SHIFT are ignored until the next LOAD.
REQ-014 In SHIFT, the FSM SHALL perform sequential double-dabble: add 3 to each BCD nibble >= 5, then shift left 1, once per cycle.
REQ-015 In DONE, the FSM SHALL write the result to bcd_out and assert bcd_valid for exactly that cycle.
REQ-016 Worst-case latency from a num change to the matching bcd_out SHALL be <= 46 cycles.
REQ-017 The scan divider SHALL count 0..CLK_FREQ/SCAN_HZ-1; on terminal count it wraps to 0 and advances the digit index 0->1->...->5->0.
REQ-018 seg_sel_n and seg_data SHALL be registered, one cycle behind the digit index: seg_sel_n = ~(1<<idx), seg_data = encode(bcd_out nibble idx).
REQ-019 The digit encoding SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); nibble >9 or blank = FF; dp is always off.
REQ-020 While en=0, seg_sel_n SHALL be 3F and seg_data FF; the divider, index and converter keep running.
REQ-021 The display SHALL only read bcd_out, so a digit never shows a partial conversion.

Reset
REQ-022 On rst_n low, asynchronously: FSM=IDLE, bcd_out=000000, bcd_valid=0, divider=0, idx=0, seg_sel_n=3F, seg_data=FF.
REQ-023 Reset asserted mid-SHIFT SHALL discard the partial result.
REQ-024 After reset release, the first conversion SHALL start on the next clk edge.

Configuration
REQ-025 The module SHALL support macro SEG_LEADING_ZERO_BLANK_EN.
REQ-026 With SEG_LEADING_ZERO_BLANK_EN defined, digits above the most-significant nonzero digit SHALL drive seg_data FF; the ones digit is always shown; seg_sel_n scanning is unchanged.
REQ-027 With SEG_LEADING_ZERO_BLANK_EN undefined, all six digits SHALL be shown, including leading zeros.

Verification
REQ-028 The bench SHALL cover: num=127 -> within 46 cycles bcd_out=000127 with one bcd_valid pulse; at idx=0, seg_sel_n=3E, seg_data=F8.
REQ-029 The bench SHALL cover: num=1048575 -> bcd_out=999999 (clamp); num=999999 -> 999999; num=0 -> 000000.
REQ-030 The bench SHALL cover: CLK_FREQ=1000, SCAN_HZ=100 -> idx advances every 10 cycles, seg_sel_n sequence 3E,3D,3B,37,2F,1F, then wraps to 3E.
REQ-031 The bench SHALL cover: with SEG_LEADING_ZERO_BLANK_EN, num=0 -> digit0 C0, digits1-5 FF; num=255 -> digits0-2 = 92,92,A4, digits3-5 FF; without the macro, digits3-5 = C0.
REQ-032 The bench SHALL cover: rst_n pulsed low 10 cycles into SHIFT with num=255 -> outputs at reset values immediately; bcd_out=000255 within 46 cycles after release.
REQ-033 The bench SHALL cover: en=0 with num=127 -> seg_sel_n=3F, seg_data=FF for a full scan cycle, while bcd_valid still pulses every 23 cycles.
